// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the non-synthesisable commit checker: processor config
// selector, error codes and the golden trace record declaration macro.
package bp_nonsynth_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg,
    e_bp_sv48_cfg
  } bp_params_e;

  localparam int unsigned bp_instr_width_gp    = 32;
  localparam int unsigned bp_dword_width_gp    = 64;
  localparam int unsigned bp_reg_addr_width_gp = 5;

  typedef enum logic [2:0] {
    e_err_none     = 3'd0,
    e_err_pc       = 3'd1,
    e_err_instr    = 3'd2,
    e_err_rd_w_v   = 3'd3,
    e_err_rd_addr  = 3'd4,
    e_err_rd_data  = 3'd5,
    e_err_overflow = 3'd6
  } bp_commit_check_err_e;

  function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_sv48_cfg: return 48;
      default:       return 39;
    endcase
  endfunction

endpackage

// Golden record, MSB first: {pc, instr, rd_w_v, rd_addr, rd_data}.
`define BP_NONSYNTH_DECLARE_COMMIT_TRACE_REC_S(vaddr_width_mp) \
  typedef struct packed { \
    logic [vaddr_width_mp-1:0]       pc; \
    logic [bp_instr_width_gp-1:0]    instr; \
    logic                            rd_w_v; \
    logic [bp_reg_addr_width_gp-1:0] rd_addr; \
    logic [bp_dword_width_gp-1:0]    rd_data; \
  } bp_commit_trace_rec_s;

// File: rtl/bsg_fifo_1r1w_small.sv
// Small synchronous-reset 1-read/1-write FIFO. A push while full is accepted
// when the head is consumed in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 8,
  localparam int unsigned ptr_w  = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned cnt_w  = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_wptr, r_rptr;
  logic [cnt_w-1:0]   r_count;
  logic               w_enq, w_deq;

  assign full_o = (r_count == cnt_w'(els_p));
  assign v_o    = (r_count != '0);
  assign data_o = r_mem[r_rptr];
  assign w_enq  = v_i && (!full_o || yumi_i);
  assign w_deq  = yumi_i && v_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= (r_wptr == ptr_w'(els_p - 1)) ? '0 : r_wptr + 1'b1;
      if (w_deq) r_rptr <= (r_rptr == ptr_w'(els_p - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_nonsynth_commit_checker.sv
// Compares the core's commit/writeback stream in program order against a
// golden trace; latches the first divergence and signals completion.
module bp_nonsynth_commit_checker
  import bp_nonsynth_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_inv_cfg,
  parameter int unsigned pend_els_p  = 8,
  parameter int unsigned max_instr_p = 0,
  localparam int unsigned vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int unsigned instr_width_p = bp_instr_width_gp,
  localparam int unsigned dword_width_p = bp_dword_width_gp,
  localparam int unsigned trace_width_p = vaddr_width_p + instr_width_p + 1 + 5 + dword_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     freeze_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [instr_width_p-1:0] commit_instr_i,
  input  logic                     commit_rd_w_v_i,
  input  logic                     rd_w_v_i,
  input  logic [4:0]               rd_addr_i,
  input  logic [dword_width_p-1:0] rd_data_i,
  input  logic                     trace_v_i,
  input  logic [trace_width_p-1:0] trace_data_i,
  output logic                     trace_yumi_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               error_code_o,
  output logic [vaddr_width_p-1:0] error_pc_o,
  output logic [31:0]              match_cnt_o
);

  `BP_NONSYNTH_DECLARE_COMMIT_TRACE_REC_S(vaddr_width_p)

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [instr_width_p-1:0] instr;
    logic                     rd_w_v;
  } pend_entry_s;

  typedef struct packed {
    logic [4:0]               rd_addr;
    logic [dword_width_p-1:0] rd_data;
  } wb_entry_s;

  typedef enum logic [1:0] {e_run, e_done, e_fail} state_e;

  state_e                r_state, w_state_n;
  bp_commit_check_err_e  r_err_code, w_err_code_n, w_mis_code;
  logic [vaddr_width_p-1:0] r_err_pc, w_err_pc_n;
  logic [31:0]           r_match_cnt, w_match_cnt_n, w_cnt_inc;
  logic [1:0]            r_rst_sync;
  logic                  w_fifo_reset;

  bp_commit_trace_rec_s  w_gold;
  pend_entry_s           w_pend_in, w_pend_head;
  wb_entry_s             w_wb_in, w_wb_head;
  logic w_pend_full, w_pend_v, w_pend_push, w_pend_pop, w_pend_req, w_pend_ovf;
  logic w_wb_full, w_wb_v, w_wb_push, w_wb_pop, w_wb_req, w_wb_ovf;
  logic w_active, w_resolved, w_cmp, w_ovf;

  // Reset synchronizer for the sync-reset FIFOs: asserts at once, releases after two edges.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_rst_sync <= '1;
    else            r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_fifo_reset = r_rst_sync[1];

  assign w_gold    = bp_commit_trace_rec_s'(trace_data_i);
  assign w_pend_in = '{pc: commit_pc_i, instr: commit_instr_i, rd_w_v: commit_rd_w_v_i};
  assign w_wb_in   = '{rd_addr: rd_addr_i, rd_data: rd_data_i};

  // Checking is also held off while the FIFOs are still being reset.
  assign w_active    = (r_state == e_run) && !freeze_i && !w_fifo_reset;
  assign w_resolved  = w_pend_v && (!w_pend_head.rd_w_v || w_wb_v);
  assign w_cmp       = w_active && w_resolved && trace_v_i;
  assign w_pend_pop  = w_cmp;
  assign w_wb_pop    = w_cmp && w_pend_head.rd_w_v;
  assign w_pend_req  = w_active && commit_v_i;
  assign w_wb_req    = w_active && rd_w_v_i;
  assign w_pend_ovf  = w_pend_req && w_pend_full && !w_pend_pop;
  assign w_wb_ovf    = w_wb_req && w_wb_full && !w_wb_pop;
  assign w_ovf       = w_pend_ovf || w_wb_ovf;
  assign w_pend_push = w_pend_req && !w_pend_ovf;
  assign w_wb_push   = w_wb_req && !w_wb_ovf;
  assign w_cnt_inc   = r_match_cnt + 32'd1;

  bsg_fifo_1r1w_small #(.width_p($bits(pend_entry_s)), .els_p(pend_els_p)) pend_fifo (
    .clk_i  (clk_i),
    .reset_i(w_fifo_reset),
    .v_i    (w_pend_push),
    .data_i (w_pend_in),
    .full_o (w_pend_full),
    .v_o    (w_pend_v),
    .data_o (w_pend_head),
    .yumi_i (w_pend_pop)
  );

  bsg_fifo_1r1w_small #(.width_p($bits(wb_entry_s)), .els_p(pend_els_p)) wb_fifo (
    .clk_i  (clk_i),
    .reset_i(w_fifo_reset),
    .v_i    (w_wb_push),
    .data_i (w_wb_in),
    .full_o (w_wb_full),
    .v_o    (w_wb_v),
    .data_o (w_wb_head),
    .yumi_i (w_wb_pop)
  );

  // Field comparison of the pending head against the golden record; first failure wins.
  always_comb begin
    w_mis_code = e_err_none;
    if (w_pend_head.pc != w_gold.pc)                                   w_mis_code = e_err_pc;
    else if (w_pend_head.instr != w_gold.instr)                        w_mis_code = e_err_instr;
    else if (w_pend_head.rd_w_v != w_gold.rd_w_v)                      w_mis_code = e_err_rd_w_v;
    else if (w_gold.rd_w_v && (w_wb_head.rd_addr != w_gold.rd_addr))   w_mis_code = e_err_rd_addr;
    else if (w_gold.rd_w_v && (w_wb_head.rd_data != w_gold.rd_data))   w_mis_code = e_err_rd_data;
  end

  // Next-state and next-output decision; overflow takes priority over a compare.
  always_comb begin
    w_state_n     = r_state;
    w_err_code_n  = r_err_code;
    w_err_pc_n    = r_err_pc;
    w_match_cnt_n = r_match_cnt;
    case (r_state)
      e_run: begin
        if (w_ovf) begin
          w_state_n    = e_fail;
          w_err_code_n = e_err_overflow;
          w_err_pc_n   = '0;
        end else if (w_cmp) begin
          if (w_mis_code != e_err_none) begin
            w_state_n    = e_fail;
            w_err_code_n = w_mis_code;
            w_err_pc_n   = w_pend_head.pc;
          end else begin
            w_match_cnt_n = w_cnt_inc;
            if ((max_instr_p != 0) && (w_cnt_inc == max_instr_p)) w_state_n = e_done;
          end
        end
      end
      default: w_state_n = r_state;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_run;
    else            r_state <= w_state_n;
  end

  // Sticky result registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_code  <= e_err_none;
      r_err_pc    <= '0;
      r_match_cnt <= '0;
    end else begin
      r_err_code  <= w_err_code_n;
      r_err_pc    <= w_err_pc_n;
      r_match_cnt <= w_match_cnt_n;
    end
  end

  assign trace_yumi_o = w_cmp;
  assign done_o       = (r_state == e_done);
  assign error_o      = (r_state == e_fail);
  assign error_code_o = r_err_code;
  assign error_pc_o   = r_err_pc;
  assign match_cnt_o  = r_match_cnt;

endmodule

// File: tb/tb_bp_nonsynth_commit_checker.sv
// Directed bench for the commit checker with a queue-based reference model.
module tb_bp_nonsynth_commit_checker;
  import bp_nonsynth_pkg::*;

  localparam int VA    = 39;
  localparam int TW    = VA + 32 + 1 + 5 + 64;
  localparam int DEPTH = 8;
  localparam int MAXI  = 5;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LUI5 = 32'h000012b7;

  logic clk = 1'b0, reset_n = 1'b0, freeze = 1'b0;
  logic commit_v = 1'b0, commit_rd_w_v = 1'b0, rd_w_v = 1'b0, trace_v = 1'b0;
  logic [VA-1:0] commit_pc = '0;
  logic [31:0]   commit_instr = '0;
  logic [4:0]    rd_addr = '0;
  logic [63:0]   rd_data = '0;
  logic [TW-1:0] trace_data = '0;
  logic trace_yumi, done, error;
  logic [2:0] error_code;
  logic [VA-1:0] error_pc;
  logic [31:0] match_cnt;

  always #5 clk = ~clk;

  bp_nonsynth_commit_checker #(.pend_els_p(DEPTH), .max_instr_p(MAXI)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
    .commit_v_i(commit_v), .commit_pc_i(commit_pc), .commit_instr_i(commit_instr),
    .commit_rd_w_v_i(commit_rd_w_v), .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .trace_v_i(trace_v), .trace_data_i(trace_data),
    .trace_yumi_o(trace_yumi), .done_o(done), .error_o(error),
    .error_code_o(error_code), .error_pc_o(error_pc), .match_cnt_o(match_cnt)
  );

  typedef struct { logic [VA-1:0] pc; logic [31:0] instr; logic rdw; } pend_t;
  typedef struct { logic [4:0] a; logic [63:0] d; } wb_t;

  pend_t pq[$];
  wb_t   wq[$];
  logic [TW-1:0] gold[$];
  int m_state;  // 0 checking, 1 done, 2 failed
  int unsigned m_cnt;
  int m_code;
  logic [VA-1:0] m_pc;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk(input logic [VA-1:0] pc, input logic [31:0] ins,
                                       input logic rdw, input logic [4:0] a, input logic [63:0] d);
    return {pc, ins, rdw, a, d};
  endfunction

  // Reference model: checks all outputs each cycle, then advances on the inputs about to be latched.
  bit c_yumi, c_ovf;
  int c_code;
  pend_t c_h;
  wb_t c_w;
  logic [TW-1:0] c_g;
  always @(negedge clk) begin
    if (!reset_n) begin
      pq.delete(); wq.delete();
      m_state = 0; m_cnt = 0; m_code = 0; m_pc = '0;
    end
    c_yumi = reset_n && m_state == 0 && !freeze && trace_v && pq.size() > 0 &&
             (!pq[0].rdw || wq.size() > 0);
    chk("trace_yumi", {63'd0, trace_yumi}, {63'd0, c_yumi});
    chk("done",       {63'd0, done},  (m_state == 1) ? 64'd1 : 64'd0);
    chk("error",      {63'd0, error}, (m_state == 2) ? 64'd1 : 64'd0);
    chk("error_code", {61'd0, error_code}, 64'(m_code));
    chk("error_pc",   {25'd0, error_pc},   {25'd0, m_pc});
    chk("match_cnt",  {32'd0, match_cnt},  64'(m_cnt));
    if (reset_n && m_state == 0 && !freeze) begin
      c_ovf = 0; c_code = 0;
      if (commit_v && pq.size() == DEPTH && !c_yumi) c_ovf = 1;
      if (rd_w_v && wq.size() == DEPTH && !(c_yumi && pq[0].rdw)) c_ovf = 1;
      if (c_yumi) begin
        c_h = pq.pop_front();
        c_g = trace_data;
        void'(gold.pop_front());
        c_w = '{a: '0, d: '0};
        if (c_h.rdw) c_w = wq.pop_front();
        if (c_g[TW-1 -: VA] != c_h.pc)               c_code = 1;
        else if (c_g[101:70] != c_h.instr)           c_code = 2;
        else if (c_g[69] != c_h.rdw)                 c_code = 3;
        else if (c_h.rdw && c_g[68:64] != c_w.a)     c_code = 4;
        else if (c_h.rdw && c_g[63:0] != c_w.d)      c_code = 5;
      end
      if (commit_v && pq.size() < DEPTH) pq.push_back('{commit_pc, commit_instr, commit_rd_w_v});
      if (rd_w_v && wq.size() < DEPTH)   wq.push_back('{rd_addr, rd_data});
      if (c_ovf) begin
        m_state = 2; m_code = 6; m_pc = '0;
      end else if (c_yumi) begin
        if (c_code != 0) begin
          m_state = 2; m_code = c_code; m_pc = c_h.pc;
        end else begin
          m_cnt++;
          if (m_cnt == MAXI) m_state = 1;
        end
      end
    end
  end

  task automatic step(input bit cv, input logic [VA-1:0] pc, input logic [31:0] ins, input bit crdw,
                      input bit wv, input logic [4:0] a, input logic [63:0] d, input bit te);
    @(posedge clk); #1;
    commit_v = cv; commit_pc = pc; commit_instr = ins; commit_rd_w_v = crdw;
    rd_w_v = wv; rd_addr = a; rd_data = d;
    trace_v    = te && gold.size() > 0;
    trace_data = (gold.size() > 0) ? gold[0] : '0;
  endtask

  task automatic idle(input int n, input bit te);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, te);
  endtask

  task automatic commit(input logic [VA-1:0] pc, input logic [31:0] ins, input bit te);
    step(1, pc, ins, 0, 0, '0, '0, te);
  endtask

  task automatic finals(input string tag, input int e_done, input int e_err,
                        input int e_code, input logic [VA-1:0] e_pc, input int e_cnt);
    chk({tag, "_done"},  {63'd0, done},  64'(e_done));
    chk({tag, "_error"}, {63'd0, error}, 64'(e_err));
    chk({tag, "_code"},  {61'd0, error_code}, 64'(e_code));
    chk({tag, "_pc"},    {25'd0, error_pc},   {25'd0, e_pc});
    chk({tag, "_cnt"},   {32'd0, match_cnt},  64'(e_cnt));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    reset_n = 1'b0;
    commit_v = 0; rd_w_v = 0; trace_v = 0;
    gold.delete();
    #1;
    finals({tag, "_async"}, 0, 0, 0, '0, 0);
    chk({tag, "_async_yumi"}, {63'd0, trace_yumi}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3, 0);
  endtask

  localparam logic [VA-1:0] BASE = 39'h0080000000;

  initial begin
    idle(3, 0);
    reset_n = 1'b1;
    idle(3, 0);
    finals("reset", 0, 0, 0, '0, 0);

    // Five plain commits, matching trace, reach max_instr_p.
    for (int k = 0; k < 5; k++) gold.push_back(mk(BASE + VA'(4 * k), NOP, 0, '0, '0));
    for (int k = 0; k < 5; k++) commit(BASE + VA'(4 * k), NOP, 1);
    idle(3, 1);
    finals("five", 1, 0, 0, '0, 5);

    // Writeback three cycles after the commit.
    do_reset("r1");
    gold.push_back(mk(BASE + 8, LUI5, 1, 5'd5, 64'h1234));
    step(1, BASE + 8, LUI5, 1, 0, '0, '0, 1);
    idle(3, 1);
    step(0, '0, '0, 0, 1, 5'd5, 64'h1234, 1);
    #1 chk("late_wb_no_yumi", {63'd0, trace_yumi}, 64'd0);
    idle(1, 1);
    #1 chk("late_wb_yumi", {63'd0, trace_yumi}, 64'd1);
    idle(2, 1);
    finals("late_wb", 0, 0, 0, '0, 1);

    // Same with wrong golden data; later commits ignored.
    do_reset("r2");
    gold.push_back(mk(BASE + 8, LUI5, 1, 5'd5, 64'h1235));
    gold.push_back(mk(BASE + 12, NOP, 0, '0, '0));
    gold.push_back(mk(BASE + 16, NOP, 0, '0, '0));
    step(1, BASE + 8, LUI5, 1, 0, '0, '0, 1);
    idle(3, 1);
    step(0, '0, '0, 0, 1, 5'd5, 64'h1234, 1);
    idle(2, 1);
    commit(BASE + 12, NOP, 1);
    commit(BASE + 16, NOP, 1);
    idle(3, 1);
    finals("rd_data", 0, 1, 5, BASE + 8, 0);

    // Instruction mismatch, then PC-and-instruction mismatch.
    do_reset("r3");
    gold.push_back(mk(BASE + 16, NOP, 0, '0, '0));
    commit(BASE + 16, ADDI, 1);
    idle(3, 1);
    finals("instr", 0, 1, 2, BASE + 16, 0);
    do_reset("r4");
    gold.push_back(mk(BASE + 20, NOP, 0, '0, '0));
    commit(BASE + 24, ADDI, 1);
    idle(3, 1);
    finals("pc_prio", 0, 1, 1, BASE + 24, 0);

    // Nine commits with no trace: the ninth overflows.
    do_reset("r5");
    for (int k = 0; k < 8; k++) commit(BASE + VA'(4 * k), NOP, 0);
    idle(1, 0);
    chk("ovf_eight_ok", {63'd0, error}, 64'd0);
    commit(BASE + 32, NOP, 0);
    idle(2, 0);
    finals("ovf", 0, 0 + 1, 6, '0, 0);

    // Full FIFO with a same-cycle pop and push: no overflow.
    do_reset("r6");
    for (int k = 0; k < 9; k++) gold.push_back(mk(BASE + VA'(4 * k), NOP, 0, '0, '0));
    for (int k = 0; k < 8; k++) commit(BASE + VA'(4 * k), NOP, 0);
    commit(BASE + 32, NOP, 1);
    idle(8, 1);
    finals("full_pp", 1, 0, 0, '0, 5);

    // Reset mid-stream with three pending entries, then a clean fresh run.
    do_reset("r7");
    for (int k = 0; k < 5; k++) gold.push_back(mk(BASE + VA'(4 * k), NOP, 0, '0, '0));
    commit(BASE, NOP, 1);
    commit(BASE + 4, NOP, 1);
    commit(BASE + 8, NOP, 1);
    commit(BASE + 12, NOP, 0);
    commit(BASE + 16, NOP, 0);
    idle(1, 0);
    finals("pre_reset", 0, 0, 0, '0, 2);
    do_reset("mid");
    gold.push_back(mk(BASE + 39'h1000, NOP, 0, '0, '0));
    gold.push_back(mk(BASE + 39'h1004, ADDI, 0, '0, '0));
    commit(BASE + 39'h1000, NOP, 1);
    commit(BASE + 39'h1004, ADDI, 1);
    idle(3, 1);
    finals("fresh", 0, 0, 0, '0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_commit_checker.md
# bp_nonsynth_commit_checker

Consumes a golden commit stream, one record per retired instruction, from a trace ROM or DPI source. Compares it in program order against the live commit and writeback ports of a BlackParrot core. Sits in the test harness beside the core, on the same commit/writeback taps the commit tracer watches. Flags the first divergence with a sticky error code and stops. Also signals completion after a programmable number of matched commits.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies vaddr_width_p (39), instr_width_p (32), dword_width_p (64).
- pend_els_p, 8, depth of the pending-commit FIFO and of the writeback FIFO.
- max_instr_p, 0, matched-commit count that ends the check; 0 means unlimited.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- freeze_i  in  1  while high, no FIFO pushes and no comparisons.
- commit_v_i  in  1  instruction retired this cycle.
- commit_pc_i  in  vaddr_width_p  retired PC.
- commit_instr_i  in  instr_width_p  retired encoding.
- commit_rd_w_v_i  in  1  retired instruction will write the integer RF (may be late).
- rd_w_v_i  in  1  RF writeback this cycle; writebacks arrive in program order.
- rd_addr_i  in  5  writeback register.
- rd_data_i  in  dword_width_p  writeback data.
- trace_v_i  in  1  golden record valid.
- trace_data_i  in  vaddr+instr+1+5+64  packed {pc, instr, rd_w_v, rd_addr, rd_data}.
- trace_yumi_o  out  1  golden record consumed this cycle.
- done_o  out  1  sticky; max_instr_p matches reached.
- error_o  out  1  sticky; first mismatch or overflow.
- error_code_o  out  3  0 none, 1 pc, 2 instr, 3 rd_w_v, 4 rd_addr, 5 rd_data, 6 overflow.
- error_pc_o  out  vaddr_width_p  DUT PC of the failing commit (0 for overflow).
- match_cnt_o  out  32  matched commits.

## Operation
- FSM states: e_run, e_done, e_fail. Reset enters e_run.
- In e_run, commit_v_i pushes {pc, instr, commit_rd_w_v_i} into the pending FIFO, and rd_w_v_i pushes {rd_addr, rd_data} into the writeback FIFO.
- The pending head is *resolved* when its rd_w_v bit is 0, or when the writeback FIFO is non-empty.
- Compare when the head is resolved and trace_v_i is high. On compare:
  - pop the pending FIFO;
  - pop the writeback FIFO if the head has rd_w_v set;
  - assert trace_yumi_o.
- Check order, first failure wins: pc, instr, rd_w_v. When rd_w_v is set on both sides, also check rd_addr, then rd_data.
- On a match, match_cnt_o increments. When max_instr_p≠0 and the count reaches max_instr_p, go to e_done.
- On a mismatch, latch error_code_o and error_pc_o, and go to e_fail.
- A push to either full FIFO is an overflow: code 6, go to e_fail. The push is dropped.
- Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- e_done and e_fail are terminal until reset. In these states, no pushes, no compares, and trace_yumi_o=0.
- If a compare and an overflow occur in the same cycle, overflow wins.

## Timing
- Reset values: all outputs 0, FIFOs empty, state e_run.
- trace_yumi_o is combinational, in the compare cycle.
- done_o, error_o, error_code_o, error_pc_o and match_cnt_o are registered and update one cycle after the deciding compare or push.
- Minimum latency: a commit with no rd write is compared the cycle after commit_v_i. One with rd write is compared the cycle after the later of commit and writeback.
- At most one compare per cycle. Throughput is one commit per cycle.
- Reset asserted mid-operation clears everything asynchronously. In-flight records are discarded.

## Structure
- Package bp_nonsynth_pkg:
  - bp_commit_check_err_e (the 3-bit codes);
  - bp_commit_trace_rec_s (the packed golden record), parameterised via a declare macro on vaddr_width_p.
- Sub-module: reuse bsg_fifo_1r1w_small twice (pending, writeback). The FSM and compare logic stay in this module.
- Synchronous-reset library FIFOs get reset from a local synchronizer of ~reset_n_i. FSM and output registers use the async reset directly.

## Test plan
- Five commits, PCs 0x80000000 + 4k, with no rd writes; matching trace → match_cnt_o=5. With max_instr_p=5, done_o=1 one cycle after the 5th yumi; error_o=0.
- Commit at 0x80000008 writes x5=0x1234, writeback 3 cycles late; trace matches → compare in the cycle after the writeback, trace_yumi_o delayed accordingly, no error.
- Same scenario, but the golden rd_data is 0x1235 → error_code_o=5, error_pc_o=0x80000008; further commits are ignored and match_cnt_o is frozen.
- Golden instr 0x00000013 vs DUT 0x00100093 at the same PC → code 2. PC and instr both differ → code 1 (priority).
- trace_v_i held low while 9 commits arrive (pend_els_p=8) → code 6 on the 9th.
- Repeat with pop and push in the same cycle at full → no error.
- reset_n_i pulsed low mid-stream with 3 pending entries → all outputs 0 immediately. After release, a fresh trace is checked cleanly from a count of 0.
